// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the XNOR LFSR generator/checker pair: the checker
// FSM states and the maximal-length tap table (XAPP052, bits numbered N..1).
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Tap k of an n-bit register maps to mask bit k-1.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Data/status bundle between a serial PRBS source and the LFSR checker.
interface lfsr_checker_if;

    logic        i_Enable;
    logic        i_Data_DV;
    logic        i_Data_Bit;
    logic        i_Clear;
    logic        o_Locked;
    logic        o_Bit_Error;
    logic [15:0] o_Error_Count;
    logic [31:0] o_Bit_Count;
    logic        o_Period_Done;

    modport master (
        output i_Enable, i_Data_DV, i_Data_Bit, i_Clear,
        input  o_Locked, o_Bit_Error, o_Error_Count, o_Bit_Count, o_Period_Done
    );

    modport slave (
        input  i_Enable, i_Data_DV, i_Data_Bit, i_Clear,
        output o_Locked, o_Bit_Error, o_Error_Count, o_Bit_Count, o_Period_Done
    );

endinterface

// File: rtl/lfsr_checker_feedback.sv
// XNOR feedback of an NUM_BITS LFSR: the next bit the generator shifts in.
module lfsr_feedback
    import lfsr_checker_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic [NUM_BITS-1:0] state_i,
    output logic                fb_o
);

    localparam logic [31:0] MASK = tap_mask(NUM_BITS);

    assign fb_o = ~^(state_i & MASK[NUM_BITS-1:0]);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: fills a local LFSR from the received
// stream, verifies LOCK_COUNT predicted bits, then flywheels on its own
// prediction and counts mismatches until UNLOCK_ERRORS in a row drop lock.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int NUM_BITS      = 8,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_ERRORS = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    lfsr_checker_if.slave       bus
);

    localparam int FILL_W  = $clog2(NUM_BITS + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int CERR_W  = $clog2(UNLOCK_ERRORS + 1);

    state_e               state_q, state_d;
    logic [NUM_BITS-1:0]  sr_q, sr_d;
    logic [NUM_BITS-1:0]  ref_q, ref_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [CERR_W-1:0]    cerr_q, cerr_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [31:0]          bit_cnt_q, bit_cnt_d;
    logic                 locked_q, locked_d;
    logic                 bit_err_q, bit_err_d;
    logic                 period_q, period_d;

    logic                 exp_bit;
    logic                 beat;
    logic                 mismatch;
    logic [NUM_BITS-1:0]  shift_rx;
    logic [NUM_BITS-1:0]  shift_exp;

    lfsr_feedback #(.NUM_BITS(NUM_BITS)) u_fb (
        .state_i (sr_q),
        .fb_o    (exp_bit)
    );

    assign beat      = bus.i_Enable & bus.i_Data_DV;
    assign mismatch  = bus.i_Data_Bit ^ exp_bit;
    assign shift_rx  = {sr_q[NUM_BITS-2:0], bus.i_Data_Bit};
    assign shift_exp = {sr_q[NUM_BITS-2:0], exp_bit};

    // Next-state: fill / verify / flywheel-check, counters and status pulses.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        ref_d     = ref_q;
        fill_d    = fill_q;
        match_d   = match_q;
        cerr_d    = cerr_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        bit_err_d = 1'b0;
        period_d  = 1'b0;
        if (beat) begin
            case (state_q)
                ST_FILL: begin
                    sr_d = shift_rx;
                    if (fill_q == FILL_W'(NUM_BITS - 1)) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    sr_d = shift_rx;
                    // All-ones is the XNOR lockup state; it predicts itself.
                    if ((&sr_q) || mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        match_d = '0;
                        cerr_d  = '0;
                        ref_d   = shift_rx;
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Shift the prediction, not the received bit, so an error
                    // does not corrupt the following predictions.
                    sr_d     = shift_exp;
                    period_d = (shift_exp == ref_q);
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
                        if (cerr_q == CERR_W'(UNLOCK_ERRORS - 1)) begin
                            cerr_d  = '0;
                            fill_d  = '0;
                            state_d = ST_FILL;
                        end else begin
                            cerr_d = cerr_q + CERR_W'(1);
                        end
                    end else begin
                        cerr_d = '0;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
        // Clear overrides any increment on the same cycle.
        if (bus.i_Enable && bus.i_Clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_FILL;
            sr_q      <= '0;
            ref_q     <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            cerr_q    <= '0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            period_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ref_q     <= ref_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cerr_q    <= cerr_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            locked_q  <= locked_d;
            bit_err_q <= bit_err_d;
            period_q  <= period_d;
        end
    end

    assign bus.o_Locked      = locked_q;
    assign bus.o_Bit_Error   = bit_err_q;
    assign bus.o_Error_Count = err_cnt_q;
    assign bus.o_Bit_Count   = bit_cnt_q;
    assign bus.o_Period_Done = period_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (NUM_BITS=8): lock timing, period pulse,
// error injection, unlock/relock, counter saturation/clear, reset, lockup.
module tb_lfsr_checker;

    logic       clk;
    logic       rst;
    logic [7:0] gen;
    int         n_tests;
    int         n_fail;
    int         rises;

    lfsr_checker_if bus ();

    lfsr_checker #(
        .NUM_BITS      (8),
        .LOCK_COUNT    (16),
        .UNLOCK_ERRORS (4)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference generator: XNOR taps 8,6,5,4.
    task automatic next_bit(output logic b);
        b   = ~^(gen & 8'hB8);
        gen = {gen[6:0], b};
    endtask

    task automatic cycle(input logic en, input logic dv, input logic b, input logic clr);
        bus.i_Enable   = en;
        bus.i_Data_DV  = dv;
        bus.i_Data_Bit = b;
        bus.i_Clear    = clr;
        @(posedge clk);
        #1;
        bus.i_Data_DV  = 1'b0;
        bus.i_Clear    = 1'b0;
    endtask

    task automatic good_beat();
        logic b;
        next_bit(b);
        cycle(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic bad_beat(input logic clr);
        logic b;
        next_bit(b);
        cycle(1'b1, 1'b1, ~b, clr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen = 8'h01;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        gen     = 8'h01;
        bus.i_Enable   = 1'b0;
        bus.i_Data_DV  = 1'b0;
        bus.i_Data_Bit = 1'b0;
        bus.i_Clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", bus.o_Locked, 0);
        check("rst_err_cnt", bus.o_Error_Count, 0);
        check("rst_bit_cnt", bus.o_Bit_Count, 0);
        check("rst_bit_err", bus.o_Bit_Error, 0);
        check("rst_period", bus.o_Period_Done, 0);
        rst = 1'b0;

        // Continuous stream: 8 fill + 16 verify beats to lock.
        repeat (23) good_beat();
        check("lock_23", bus.o_Locked, 0);
        good_beat();
        check("lock_24", bus.o_Locked, 1);
        check("lock_bit_cnt", bus.o_Bit_Count, 0);

        // Period pulse after every 255 locked beats.
        for (int k = 1; k <= 510; k++) begin
            good_beat();
            check("period", bus.o_Period_Done, (k == 255 || k == 510) ? 1 : 0);
        end
        check("clean_err_cnt", bus.o_Error_Count, 0);
        check("clean_bit_cnt", bus.o_Bit_Count, 510);

        // Single error.
        bad_beat(1'b0);
        check("single_bit_err", bus.o_Bit_Error, 1);
        check("single_err_cnt", bus.o_Error_Count, 1);
        check("single_locked", bus.o_Locked, 1);
        good_beat();
        check("single_next_bit_err", bus.o_Bit_Error, 0);
        check("single_next_err_cnt", bus.o_Error_Count, 1);
        check("single_bit_cnt", bus.o_Bit_Count, 512);

        // Clear, then four consecutive errors drop lock.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("clear_err_cnt", bus.o_Error_Count, 0);
        check("clear_bit_cnt", bus.o_Bit_Count, 0);
        repeat (3) bad_beat(1'b0);
        check("unlock_3", bus.o_Locked, 1);
        bad_beat(1'b0);
        check("unlock_4", bus.o_Locked, 0);
        check("unlock_err_cnt", bus.o_Error_Count, 4);
        check("unlock_bit_err", bus.o_Bit_Error, 1);
        repeat (23) good_beat();
        check("relock_23", bus.o_Locked, 0);
        good_beat();
        check("relock_24", bus.o_Locked, 1);
        check("relock_bit_cnt", bus.o_Bit_Count, 4);

        // Error counter saturation: 3 errors + 1 clean keeps lock.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 21845; g++) begin
            repeat (3) bad_beat(1'b0);
            good_beat();
        end
        check("sat_reach", bus.o_Error_Count, 16'hFFFF);
        check("sat_locked", bus.o_Locked, 1);
        bad_beat(1'b0);
        good_beat();
        check("sat_hold", bus.o_Error_Count, 16'hFFFF);
        bad_beat(1'b1);
        check("clear_on_err", bus.o_Error_Count, 0);
        check("clear_on_err_bc", bus.o_Bit_Count, 0);
        check("clear_on_err_pulse", bus.o_Bit_Error, 1);

        // Asynchronous reset between edges while locked.
        bad_beat(1'b0);
        check("pre_rst_err_cnt", bus.o_Error_Count, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_locked", bus.o_Locked, 0);
        check("async_err_cnt", bus.o_Error_Count, 0);
        check("async_bit_cnt", bus.o_Bit_Count, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All-ones stream never locks.
        rises = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            if (bus.o_Locked !== 1'b0) rises++;
        end
        check("ones_lock_seen", rises, 0);
        check("ones_locked", bus.o_Locked, 0);

        // Lock timing unaffected by DV gaps and disabled cycles.
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            good_beat();
            if (i == 23) check("gap_lock_23", bus.o_Locked, 0);
            if (i % 3 == 0) cycle(1'b1, 1'b0, 1'b1, 1'b0);
            if (i % 5 == 0) begin
                cycle(1'b0, 1'b1, ~gen[0], 1'b0);
                check("disabled_bit_err", bus.o_Bit_Error, 0);
            end
        end
        check("gap_lock_24", bus.o_Locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL take parameter NUM_BITS, default 8, as the LFSR length; legal range 3..32.
REQ-002 The block SHALL take parameter LOCK_COUNT, default 16, as the consecutive matching bits required to declare lock.
REQ-003 The block SHALL take parameter UNLOCK_ERRORS, default 4, as the consecutive mismatching bits that drop lock.
REQ-004 i_Clk  input  1  single clock, all state on rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Enable  input  1  when low, all state frozen and o_Bit_Error low.
REQ-007 i_Data_DV  input  1  i_Data_Bit valid this cycle.
REQ-008 i_Data_Bit  input  1  received serial bit: the feedback bit produced by the generator on each shift.
REQ-009 i_Clear  input  1  synchronous clear of o_Error_Count and o_Bit_Count.
REQ-010 o_Locked  output  1  high in LOCKED state.
REQ-011 o_Bit_Error  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 o_Error_Count  output  16  saturating mismatch count while LOCKED.
REQ-013 o_Bit_Count  output  32  saturating count of bits checked while LOCKED.
REQ-014 o_Period_Done  output  1  one-cycle pulse when the local register returns to its value at lock entry.

Function
REQ-015 Expected bit SHALL be the inverted XOR of the tap bits of the local NUM_BITS register (bits numbered NUM_BITS..1), taps per the shared Xilinx XAPP052 tap table.
REQ-016 A beat SHALL be a cycle with i_Enable=1 and i_Data_DV=1; no state changes on any other cycle.
REQ-017 FSM states SHALL be FILL, VERIFY, LOCKED; reset state FILL.
REQ-018 FILL: each beat shifts i_Data_Bit into bit 1 (register shifts toward bit NUM_BITS); after NUM_BITS beats go to VERIFY with match counter 0.
REQ-019 VERIFY: each beat compares i_Data_Bit to expected, then shifts in the received bit; match increments match counter, mismatch zeroes it.
REQ-020 VERIFY SHALL hold the match counter at 0 while the register is all ones (XNOR lockup state), so an all-ones stream never locks.
REQ-021 VERIFY to LOCKED SHALL occur on the beat the match counter reaches LOCK_COUNT; the register value after that beat is captured as the period reference.
REQ-022 LOCKED: each beat shifts in the expected bit (flywheel), not the received bit, so single errors do not propagate.
REQ-023 LOCKED mismatch SHALL pulse o_Bit_Error in the cycle after the beat, increment o_Error_Count and the consecutive-error counter; a match zeroes the consecutive-error counter.
REQ-024 LOCKED SHALL return to FILL with fill counter 0 on the beat the consecutive-error counter reaches UNLOCK_ERRORS; counts are retained.
REQ-025 o_Bit_Count SHALL increment once per LOCKED beat; both counters saturate at all ones, no wrap.
REQ-026 i_Clear SHALL zero both counters; simultaneous i_Clear and a counted event leaves the counter at 0.
REQ-027 o_Period_Done SHALL pulse the cycle after a LOCKED beat whose shifted register equals the period reference.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 i_Rst SHALL immediately force state FILL, register, fill/match/consecutive-error counters and all outputs to 0, including mid-operation.
REQ-030 The first beat after i_Rst deasserts SHALL be fill bit 1 of NUM_BITS.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the tap-mask function (NUM_BITS -> 32-bit mask) used by both generator and checker.
REQ-032 The expected-bit computation SHALL be one sub-module, lfsr_feedback, parameterised by NUM_BITS.

Verification
REQ-033 NUM_BITS=8, generator seeded 8'h01, continuous beats -> o_Locked rises after 8+16 beats; o_Error_Count stays 0; o_Period_Done pulses every 255 LOCKED beats.
REQ-034 Locked, one bit inverted -> exactly one o_Bit_Error pulse, o_Error_Count=1, o_Locked stays 1, next bit checks clean.
REQ-035 Locked, 4 consecutive inverted bits -> o_Locked falls after 4th beat, o_Error_Count=4, relock after 24 clean beats.
REQ-036 All-ones stream for 100 beats -> o_Locked stays 0.
REQ-037 o_Error_Count preloaded near 16'hFFFF by error injection -> holds at 16'hFFFF; i_Clear on an error beat -> 0.
REQ-038 i_Rst asserted mid-LOCKED between clock edges -> o_Locked and counts 0 before next edge; DV gaps and i_Enable=0 cycles do not alter lock timing.
